kiu_int_receiver: RTL and testbench
===================================

# kiu_int_receiver

Kernel-side receiver for the external interrupt controller's request/acknowledge protocol. It synchronizes the single-cycle request pulse and the interrupt-type bit into the CPU clock domain, then holds one interrupt pending for the pipeline. Normal interrupts are gated by the CPU interrupt-enable bit; urgent interrupts are not. When the pipeline commits the trap, the block returns the toggle-style acknowledge to the controller. It sits inside the kernel interrupt unit (KIU), between the peripheral bus interrupt controller and the pipeline trap logic.

## Interface
Parameters:
- IRQ_VECTOR, default KIU_IRQ_VECTOR (32'h0000_0008): handler address for a normal interrupt.
- URQ_VECTOR, default KIU_URQ_VECTOR (32'h0000_0004): handler address for an urgent interrupt.

Ports:
- Clock  in  1  CPU clock.
- Reset  in  1  asynchronous, active-high.
- EIC_IntReq  in  1  request pulse from the controller, asynchronous to Clock.
- EIC_IntId  in  1  interrupt type: 0 = normal IRQ, 1 = urgent URQ. Asynchronous to Clock.
- EIC_IntAck  out  1  acknowledge. Each transition is one acknowledge (toggle protocol).
- IntEnable  in  1  CPU interrupt-enable bit. Masks normal interrupts only.
- IntTaken  in  1  single-cycle pulse from the pipeline when it commits the trap.
- IntTrap  out  1  trap request to the pipeline.
- IntUrgent  out  1  type of the pending interrupt.
- IntVector  out  32  handler address.
- ErrorFlag  out  1  sticky protocol error. Present only with the configuration macro.
- ErrorClr  in  1  clears ErrorFlag. Present only with the configuration macro.

## Operation
- Request path:
  - EIC_IntReq passes through a 2-flop synchronizer, then a registered last-value flop.
  - A rising edge is detected as sync & ~last.
  - EIC_IntId passes through its own 2-flop synchronizer.
  - The controller guarantees EIC_IntId is stable at least one controller cycle before the request and until the acknowledge. The synchronized EIC_IntId is therefore valid when the edge is detected.
- State machine states: IDLE, PENDING, ACK.
  - IDLE -> PENDING on a detected edge. At the same clock edge the synchronized EIC_IntId is captured into the urgent register.
  - PENDING -> ACK when IntTaken = 1 and IntTrap = 1. At the same clock edge EIC_IntAck toggles.
  - ACK -> IDLE unconditionally after one cycle.
- Outputs:
  - IntTrap = (State == PENDING) & (urgent | IntEnable). It is combinational from registers and IntEnable.
  - IntUrgent = urgent register.
  - IntVector = URQ_VECTOR when urgent, otherwise IRQ_VECTOR.
- Boundary conditions:
  - IntTaken while IntTrap = 0 (any state, or a masked IRQ) is ignored.
  - A normal IRQ stays PENDING indefinitely while IntEnable = 0. IntTrap rises combinationally when IntEnable rises.
  - A detected edge in PENDING or ACK is a protocol violation. It is dropped, and the state, the urgent register and EIC_IntAck are unchanged.
  - Only one request is ever outstanding. The controller waits for the ack transition before it issues another request.
- Reset values:
  - State = IDLE; urgent = 0; EIC_IntAck = 0.
  - All synchronizer and last-value flops = 0.
  - Therefore IntTrap = 0, IntUrgent = 0, IntVector = IRQ_VECTOR.
  - ErrorFlag = 0.
- Reset during PENDING discards the interrupt. Controller and receiver share the system reset, so acknowledge parity realigns to 0 on both sides.

## Timing
- Let N be the first clock edge that samples EIC_IntReq = 1.
  - Synchronizer output is high after edge N+1.
  - The edge is detected during the cycle after N+1.
  - State becomes PENDING at edge N+2, so IntTrap is high in the cycle after N+2 (if unmasked).
- IntTaken sampled at edge M: EIC_IntAck toggles at edge M, IntTrap falls after edge M, State returns to IDLE at edge M+1.
- The earliest next acceptance is the next detected edge after IDLE is re-entered.
- Clock constraint: the EIC_IntReq pulse (one controller clock cycle) must be at least 1.5 Clock periods wide. The controller clock must not exceed Clock / 1.5.

## Configuration
- Macro: KIU_INT_RX_ERRCHK_EN.
- Defined:
  - ErrorFlag and ErrorClr ports exist.
  - ErrorFlag sets on a detected edge in PENDING or ACK, and holds until ErrorClr.
  - If set and clear coincide, set wins.
- Undefined:
  - The ports and the flop are absent.
  - Violating edges are silently dropped.

## Structure
- Shared package kiu_pkg holds:
  - KIU_IRQ_VECTOR and KIU_URQ_VECTOR constants.
  - The state enum typedef kiu_rx_state_t {IDLE, PENDING, ACK}.
- One sub-module, int_req_sync: a 2-flop synchronizer plus last-value flop, active-high asynchronous reset. Outputs the synchronized level and a rising-edge pulse.
  - Instantiated once for EIC_IntReq.
  - EIC_IntId uses a plain 2-flop chain within the top module.

## Test plan
- Unmasked IRQ:
  - Stimulus: IntEnable = 1, EIC_IntId = 0, one 2-cycle EIC_IntReq pulse.
  - Response: IntTrap = 1 three edges after first sample, IntVector = 32'h8, IntUrgent = 0.
  - Then IntTaken pulse: EIC_IntAck 0 -> 1 at the same edge, IntTrap = 0 next cycle.
- Masked URQ:
  - Stimulus: IntEnable = 0, EIC_IntId = 1, request.
  - Response: IntTrap = 1, IntVector = 32'h4.
  - Then IntTaken: EIC_IntAck toggles.
- Masked IRQ:
  - Stimulus: IntEnable = 0, IRQ request, IntTaken pulses for 20 cycles.
  - Response: IntTrap = 0 and EIC_IntAck unchanged.
  - Then raise IntEnable: IntTrap = 1 the same cycle.
- Back-to-back:
  - Stimulus: two IRQ/URQ sequences.
  - Response: EIC_IntAck 0 -> 1 -> 0, with IntUrgent matching each request.
- Violation (macro defined):
  - Stimulus: second request while PENDING.
  - Response: state unchanged, ErrorFlag = 1 until ErrorClr.
  - Same stimulus with macro undefined: no effect.
- Reset during PENDING:
  - Response: IntTrap = 0, EIC_IntAck = 0, IntVector = 32'h8 immediately (asynchronous).
  - A subsequent request is accepted normally.

Source files
------------

// File: rtl/kiu_pkg.sv
// ============================================================================
// Module      : kiu_pkg
// Description : Shared constants and types for the kernel interrupt unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package kiu_pkg;

  localparam logic [31:0] KIU_IRQ_VECTOR = 32'h0000_0008;
  localparam logic [31:0] KIU_URQ_VECTOR = 32'h0000_0004;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    ACK     = 2'd2
  } kiu_rx_state_t;

endpackage

`default_nettype wire

// File: rtl/kiu_int_receiver_if.sv
// ============================================================================
// Module      : kiu_int_receiver_if
// Description : Controller/pipeline signals of the interrupt receiver.
//               ErrorFlag/ErrorClr exist only with KIU_INT_RX_ERRCHK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface kiu_int_receiver_if;

  logic        EIC_IntReq;
  logic        EIC_IntId;
  logic        EIC_IntAck;
  logic        IntEnable;
  logic        IntTaken;
  logic        IntTrap;
  logic        IntUrgent;
  logic [31:0] IntVector;
`ifdef KIU_INT_RX_ERRCHK_EN
  logic        ErrorFlag;
  logic        ErrorClr;
`endif

`ifdef KIU_INT_RX_ERRCHK_EN
  modport master (
    output EIC_IntReq, EIC_IntId, IntEnable, IntTaken, ErrorClr,
    input  EIC_IntAck, IntTrap, IntUrgent, IntVector, ErrorFlag
  );
  modport slave (
    input  EIC_IntReq, EIC_IntId, IntEnable, IntTaken, ErrorClr,
    output EIC_IntAck, IntTrap, IntUrgent, IntVector, ErrorFlag
  );
`else
  modport master (
    output EIC_IntReq, EIC_IntId, IntEnable, IntTaken,
    input  EIC_IntAck, IntTrap, IntUrgent, IntVector
  );
  modport slave (
    input  EIC_IntReq, EIC_IntId, IntEnable, IntTaken,
    output EIC_IntAck, IntTrap, IntUrgent, IntVector
  );
`endif

endinterface

`default_nettype wire

// File: rtl/int_req_sync.sv
// ============================================================================
// Module      : int_req_sync
// Description : 2-flop synchronizer with last-value flop and rising-edge pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module int_req_sync (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_async,
  output logic      o_level,
  output logic      o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_last <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_last <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_sync & ~r_last;

endmodule

`default_nettype wire

// File: rtl/kiu_int_receiver.sv
// ============================================================================
// Module      : kiu_int_receiver
// Description : Receives EIC request pulses, holds one interrupt pending for
//               the pipeline and returns a toggle acknowledge on commit.
//               Optional protocol error flag: KIU_INT_RX_ERRCHK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module kiu_int_receiver
  import kiu_pkg::*;
#(
  parameter logic [31:0] IRQ_VECTOR = KIU_IRQ_VECTOR,
  parameter logic [31:0] URQ_VECTOR = KIU_URQ_VECTOR
) (
  input  wire logic          Clock,
  input  wire logic          Reset,
  kiu_int_receiver_if.slave  bus
);

  kiu_rx_state_t r_state;
  logic          r_urgent;
  logic          r_ack;
  logic          r_id_meta;
  logic          r_id_sync;
  logic          w_req_level;
  logic          w_req_rise;
  logic          w_edge;
  logic          w_trap;
  logic          w_take;

  int_req_sync u_req_sync (
    .clk     (Clock),
    .rst     (Reset),
    .i_async (bus.EIC_IntReq),
    .o_level (w_req_level),
    .o_rise  (w_req_rise)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_id_meta <= 1'b0;
      r_id_sync <= 1'b0;
    end else begin
      r_id_meta <= bus.EIC_IntId;
      r_id_sync <= r_id_meta;
    end
  end

  assign w_edge = w_req_rise & w_req_level;
  assign w_trap = (r_state == PENDING) & (r_urgent | bus.IntEnable);
  assign w_take = w_trap & bus.IntTaken;

  // Edges outside IDLE are protocol violations and are dropped here.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state  <= IDLE;
      r_urgent <= 1'b0;
      r_ack    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_edge) begin
            r_state  <= PENDING;
            r_urgent <= r_id_sync;
          end
        end
        PENDING: begin
          if (w_take) begin
            r_state <= ACK;
            r_ack   <= ~r_ack;
          end
        end
        ACK:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef KIU_INT_RX_ERRCHK_EN
  logic r_err;

  // Set has priority over a coincident clear.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_err <= 1'b0;
    end else if (w_edge && (r_state != IDLE)) begin
      r_err <= 1'b1;
    end else if (bus.ErrorClr) begin
      r_err <= 1'b0;
    end
  end

  assign bus.ErrorFlag = r_err;
`endif

  assign bus.EIC_IntAck = r_ack;
  assign bus.IntTrap    = w_trap;
  assign bus.IntUrgent  = r_urgent;
  assign bus.IntVector  = r_urgent ? URQ_VECTOR : IRQ_VECTOR;

endmodule

`default_nettype wire

// File: tb/tb_kiu_int_receiver.sv
// ============================================================================
// Module      : tb_kiu_int_receiver
// Description : Directed self-checking bench for kiu_int_receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_kiu_int_receiver;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  kiu_int_receiver_if bus ();

  kiu_int_receiver u_dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Id is set a cycle ahead; after return we sit just past edge N+2.
  task automatic req_pulse(input logic id);
    bus.EIC_IntId = id;
    step();
    bus.EIC_IntReq = 1'b1;
    step();
    step();
    bus.EIC_IntReq = 1'b0;
    step();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.EIC_IntReq = 1'b0;
    bus.EIC_IntId  = 1'b0;
    bus.IntEnable  = 1'b0;
    bus.IntTaken   = 1'b0;
`ifdef KIU_INT_RX_ERRCHK_EN
    bus.ErrorClr   = 1'b0;
`endif
    repeat (3) step();
    rst = 1'b0;
    step();

    chk("rst_trap",   {31'd0, bus.IntTrap},    32'd0);
    chk("rst_ack",    {31'd0, bus.EIC_IntAck}, 32'd0);
    chk("rst_urgent", {31'd0, bus.IntUrgent},  32'd0);
    chk("rst_vector", bus.IntVector,           32'h8);
`ifdef KIU_INT_RX_ERRCHK_EN
    chk("rst_err",    {31'd0, bus.ErrorFlag},  32'd0);
`endif

    // Unmasked IRQ: check latency edge by edge
    bus.IntEnable = 1'b1;
    bus.EIC_IntId = 1'b0;
    step();
    bus.EIC_IntReq = 1'b1;
    step();
    chk("irq_trap_n", {31'd0, bus.IntTrap}, 32'd0);
    step();
    bus.EIC_IntReq = 1'b0;
    chk("irq_trap_n1", {31'd0, bus.IntTrap}, 32'd0);
    step();
    chk("irq_trap_n2",  {31'd0, bus.IntTrap},   32'd1);
    chk("irq_vector",   bus.IntVector,          32'h8);
    chk("irq_urgent",   {31'd0, bus.IntUrgent}, 32'd0);
    bus.IntTaken = 1'b1;
    step();
    bus.IntTaken = 1'b0;
    chk("irq_ack",       {31'd0, bus.EIC_IntAck}, 32'd1);
    chk("irq_trap_fall", {31'd0, bus.IntTrap},    32'd0);
    step();

    // Masked URQ: urgent ignores IntEnable
    bus.IntEnable = 1'b0;
    req_pulse(1'b1);
    chk("urq_trap",   {31'd0, bus.IntTrap},   32'd1);
    chk("urq_vector", bus.IntVector,          32'h4);
    chk("urq_urgent", {31'd0, bus.IntUrgent}, 32'd1);
    bus.IntTaken = 1'b1;
    step();
    bus.IntTaken = 1'b0;
    chk("urq_ack", {31'd0, bus.EIC_IntAck}, 32'd0);
    step();

    // Masked IRQ: IntTaken ignored while masked
    req_pulse(1'b0);
    chk("mirq_trap",   {31'd0, bus.IntTrap},   32'd0);
    chk("mirq_urgent", {31'd0, bus.IntUrgent}, 32'd0);
    bus.IntTaken = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
    end
    bus.IntTaken = 1'b0;
    chk("mirq_trap_hold", {31'd0, bus.IntTrap},    32'd0);
    chk("mirq_ack_hold",  {31'd0, bus.EIC_IntAck}, 32'd0);
    bus.IntEnable = 1'b1;
    #1;
    chk("mirq_trap_comb", {31'd0, bus.IntTrap}, 32'd1);
    bus.IntEnable = 1'b0;

    // Violation: second request (urgent type) while PENDING
    #1;
    req_pulse(1'b1);
    step();
    chk("viol_trap",   {31'd0, bus.IntTrap},    32'd0);
    chk("viol_urgent", {31'd0, bus.IntUrgent},  32'd0);
    chk("viol_ack",    {31'd0, bus.EIC_IntAck}, 32'd0);
`ifdef KIU_INT_RX_ERRCHK_EN
    chk("viol_err_set", {31'd0, bus.ErrorFlag}, 32'd1);
    step();
    chk("viol_err_hold", {31'd0, bus.ErrorFlag}, 32'd1);
    bus.ErrorClr = 1'b1;
    step();
    bus.ErrorClr = 1'b0;
    chk("viol_err_clr", {31'd0, bus.ErrorFlag}, 32'd0);
`endif
    bus.IntEnable = 1'b1;
    #1;
    chk("viol_still_pend", {31'd0, bus.IntTrap}, 32'd1);
    bus.IntTaken = 1'b1;
    step();
    bus.IntTaken = 1'b0;
    chk("viol_ack_after", {31'd0, bus.EIC_IntAck}, 32'd1);
    step();

    // Reset during PENDING clears asynchronously
    bus.IntEnable = 1'b0;
    req_pulse(1'b1);
    chk("rp_pending_vec", bus.IntVector, 32'h4);
    #2;
    rst = 1'b1;
    #1;
    chk("rp_trap",   {31'd0, bus.IntTrap},    32'd0);
    chk("rp_ack",    {31'd0, bus.EIC_IntAck}, 32'd0);
    chk("rp_vector", bus.IntVector,           32'h8);
    step();
    #2;
    rst = 1'b0;
    step();
    bus.IntEnable = 1'b1;
    req_pulse(1'b0);
    chk("rp_new_trap", {31'd0, bus.IntTrap}, 32'd1);
    bus.IntTaken = 1'b1;
    step();
    bus.IntTaken = 1'b0;
    chk("rp_new_ack", {31'd0, bus.EIC_IntAck}, 32'd1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
